// File: rtl/clk_enable_gen.sv
`default_nettype none
// ============================================================================
// Module   : clk_enable_gen
// Purpose  : PLL lock qualification, downstream reset sequencing and
//            NUM_CH programmable single-cycle clock-enable strobes.
// Revision : 1.0
// ============================================================================
module clk_enable_gen #(
    parameter int NUM_CH      = 2,
    parameter int DIV_WIDTH   = 8,
    parameter int DEFAULT_DIV = 60,
    parameter int LOCK_WAIT   = 1024,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 in_clk,
    input  logic                 in_reset,
    input  logic                 in_pll_lock,
    input  logic [NUM_CH-1:0]    in_div_load,
    input  logic [DIV_WIDTH-1:0] in_div_value,
    input  logic                 in_clear_lost,
    output logic [NUM_CH-1:0]    out_ce,
    output logic                 out_rst,
    output logic                 out_ready,
    output logic                 out_lock_lost
);

    localparam int                    SETTLE_W      = (LOCK_WAIT > 1) ? $clog2(LOCK_WAIT) : 1;
    localparam logic [SETTLE_W-1:0]   c_SETTLE_LAST = SETTLE_W'(LOCK_WAIT - 1);
    localparam logic [DIV_WIDTH-1:0]  c_DEFAULT_DIV = DIV_WIDTH'(DEFAULT_DIV);

    typedef enum logic [1:0] {
        ST_WAIT_LOCK = 2'd0,
        ST_SETTLE    = 2'd1,
        ST_RUN       = 2'd2
    } state_t;

    state_t                 r_state;
    state_t                 w_next_state;
    logic [SYNC_STAGES-1:0] r_sync;
    logic                   w_lock_s;
    logic [SETTLE_W-1:0]    r_settle;
    logic [SETTLE_W-1:0]    w_settle_next;
    logic                   r_rst;
    logic                   r_ready;
    logic                   r_lost;

    assign w_lock_s = r_sync[SYNC_STAGES-1];

    always_ff @(posedge in_clk or posedge in_reset) begin
        if (in_reset) begin
            r_sync   <= '0;
            r_state  <= ST_WAIT_LOCK;
            r_settle <= '0;
            r_rst    <= 1'b1;
            r_ready  <= 1'b0;
            r_lost   <= 1'b0;
        end else begin
            r_sync   <= {r_sync[SYNC_STAGES-2:0], in_pll_lock};
            r_state  <= w_next_state;
            r_settle <= w_settle_next;
            r_rst    <= (w_next_state != ST_RUN);
            r_ready  <= (w_next_state == ST_RUN);
            if (r_state == ST_RUN && !w_lock_s) begin
                r_lost <= 1'b1;
            end else if (in_clear_lost) begin
                r_lost <= 1'b0;
            end
        end
    end

    // The settle counter holds the number of consecutive locked cycles seen,
    // so the cycle that first sees lock counts as 1 of LOCK_WAIT.
    always_comb begin
        w_next_state  = r_state;
        w_settle_next = '0;
        case (r_state)
            ST_WAIT_LOCK: begin
                if (w_lock_s) begin
                    if (LOCK_WAIT == 1) begin
                        w_next_state = ST_RUN;
                    end else begin
                        w_next_state  = ST_SETTLE;
                        w_settle_next = SETTLE_W'(1);
                    end
                end
            end
            ST_SETTLE: begin
                if (!w_lock_s) begin
                    w_next_state = ST_WAIT_LOCK;
                end else if (r_settle == c_SETTLE_LAST) begin
                    w_next_state = ST_RUN;
                end else begin
                    w_settle_next = r_settle + SETTLE_W'(1);
                end
            end
            ST_RUN: begin
                if (!w_lock_s) begin
                    w_next_state = ST_WAIT_LOCK;
                end
            end
            default: begin
                w_next_state = ST_WAIT_LOCK;
            end
        endcase
    end

    assign out_rst       = r_rst;
    assign out_ready     = r_ready;
    assign out_lock_lost = r_lost;

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
        logic [DIV_WIDTH-1:0] r_cnt;
        logic [DIV_WIDTH-1:0] r_active;
        logic [DIV_WIDTH-1:0] r_shadow;
        logic                 r_ce;
        logic [DIV_WIDTH-1:0] w_last;
        logic [DIV_WIDTH-1:0] w_last_next;
        logic [DIV_WIDTH-1:0] w_cnt_next;
        logic [DIV_WIDTH-1:0] w_active_next;
        logic [DIV_WIDTH-1:0] w_shadow_next;
        logic                 w_term;
        logic                 w_ce_next;

        // Divisors 0 and 1 both give a terminal count of 0 (strobe every cycle).
        // The strobe is registered from next-cycle counter/divisor values.
        always_comb begin
            w_last        = (r_active > DIV_WIDTH'(1)) ? (r_active - DIV_WIDTH'(1)) : '0;
            w_term        = (r_state == ST_RUN) && (r_cnt == w_last);
            w_shadow_next = in_div_load[gi] ? in_div_value : r_shadow;
            w_active_next = ((r_state != ST_RUN) || w_term) ? w_shadow_next : r_active;
            if ((r_state != ST_RUN) || (w_next_state != ST_RUN) || w_term) begin
                w_cnt_next = '0;
            end else begin
                w_cnt_next = r_cnt + DIV_WIDTH'(1);
            end
            w_last_next = (w_active_next > DIV_WIDTH'(1)) ? (w_active_next - DIV_WIDTH'(1)) : '0;
            w_ce_next   = (w_next_state == ST_RUN) && (w_cnt_next == w_last_next);
        end

        always_ff @(posedge in_clk or posedge in_reset) begin
            if (in_reset) begin
                r_cnt    <= '0;
                r_active <= c_DEFAULT_DIV;
                r_shadow <= c_DEFAULT_DIV;
                r_ce     <= 1'b0;
            end else begin
                r_cnt    <= w_cnt_next;
                r_active <= w_active_next;
                r_shadow <= w_shadow_next;
                r_ce     <= w_ce_next;
            end
        end

        assign out_ce[gi] = r_ce;
    end

endmodule
`default_nettype wire

// File: tb/tb_clk_enable_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_clk_enable_gen
// Purpose  : Self-checking bench for clk_enable_gen (LOCK_WAIT=16, 2 channels).
// Revision : 1.0
// ============================================================================
module tb_clk_enable_gen;

    logic       clk = 1'b0;
    logic       rst;
    logic       pll_lock;
    logic [1:0] div_load;
    logic [7:0] div_value;
    logic       clear_lost;
    logic [1:0] ce;
    logic       orst;
    logic       ready;
    logic       lost;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string      tag;
        logic [4:0] exp;
    } sb_t;
    sb_t sb[$];

    typedef struct {
        logic       load;
        logic [7:0] d0;
        logic [7:0] d1;
        int         cycles;
    } vec_t;
    vec_t vecs[4];

    always #5 clk = ~clk;

    clk_enable_gen #(
        .NUM_CH      (2),
        .DIV_WIDTH   (8),
        .DEFAULT_DIV (60),
        .LOCK_WAIT   (16),
        .SYNC_STAGES (2)
    ) dut (
        .in_clk        (clk),
        .in_reset      (rst),
        .in_pll_lock   (pll_lock),
        .in_div_load   (div_load),
        .in_div_value  (div_value),
        .in_clear_lost (clear_lost),
        .out_ce        (ce),
        .out_rst       (orst),
        .out_ready     (ready),
        .out_lock_lost (lost)
    );

    function automatic logic ce_at(int d, int k);
        if (d <= 1) return 1'b1;
        return (k % d) == 0;
    endfunction

    task automatic push(string tag, logic [1:0] c, logic r, logic rd, logic l);
        sb_t e;
        e.tag = tag;
        e.exp = {c, r, rd, l};
        sb.push_back(e);
    endtask

    task automatic pop_check();
        sb_t        e;
        logic [4:0] act;
        act = {ce, orst, ready, lost};
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL scoreboard_empty: got %b, no expectation queued", act);
        end else begin
            e = sb.pop_front();
            if (act !== e.exp) begin
                errors++;
                $display("FAIL %s @%0t: got {ce,rst,ready,lost}=%b required %b",
                         e.tag, $time, act, e.exp);
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic cyc(string tag, logic [1:0] c, logic r, logic rd, logic l);
        push(tag, c, r, rd, l);
        step();
        pop_check();
    endtask

    task automatic apply_reset();
        rst        = 1'b1;
        pll_lock   = 1'b0;
        div_load   = 2'b00;
        div_value  = 8'd0;
        clear_lost = 1'b0;
        step();
        cyc("reset_state", 2'b00, 1'b1, 1'b0, 1'b0);
        rst = 1'b0;
    endtask

    // Lock was driven high just before calling: 2 sync cycles + LOCK_WAIT.
    task automatic wait_run(int d0, int d1, logic l);
        for (int k = 1; k <= 17; k++) begin
            cyc("settle_hold", 2'b00, 1'b1, 1'b0, l);
        end
        cyc("run_entry", {ce_at(d1, 1), ce_at(d0, 1)}, 1'b0, 1'b1, l);
    endtask

    task automatic run_check(string tag, int d0, int d1, int kfrom, int kto, logic l);
        for (int k = kfrom; k <= kto; k++) begin
            cyc(tag, {ce_at(d1, k), ce_at(d0, k)}, 1'b0, 1'b1, l);
        end
    endtask

    initial begin
        vecs[0] = '{1'b0, 8'd60, 8'd60, 125};
        vecs[1] = '{1'b1, 8'd5,  8'd3,  20};
        vecs[2] = '{1'b1, 8'd1,  8'd0,  10};
        vecs[3] = '{1'b1, 8'd2,  8'd7,  20};

        rst        = 1'b1;
        pll_lock   = 1'b0;
        div_load   = 2'b00;
        div_value  = 8'd0;
        clear_lost = 1'b0;

        // Table: divisor pairs programmed before lock, then periodic strobes.
        for (int v = 0; v < 4; v++) begin
            apply_reset();
            if (vecs[v].load) begin
                div_value = vecs[v].d0;
                div_load  = 2'b01;
                cyc("preload_ch0", 2'b00, 1'b1, 1'b0, 1'b0);
                div_value = vecs[v].d1;
                div_load  = 2'b10;
                cyc("preload_ch1", 2'b00, 1'b1, 1'b0, 1'b0);
                div_load  = 2'b00;
            end
            pll_lock = 1'b1;
            wait_run(int'(vecs[v].d0), int'(vecs[v].d1), 1'b0);
            run_check("div_table", int'(vecs[v].d0), int'(vecs[v].d1), 2, vecs[v].cycles, 1'b0);
        end

        // Lock glitch during settle restarts the qualification window.
        apply_reset();
        pll_lock = 1'b1;
        for (int k = 0; k < 8; k++) cyc("glitch_pre", 2'b00, 1'b1, 1'b0, 1'b0);
        pll_lock = 1'b0;
        cyc("glitch_low", 2'b00, 1'b1, 1'b0, 1'b0);
        pll_lock = 1'b1;
        wait_run(60, 60, 1'b0);
        run_check("glitch_run", 60, 60, 2, 4, 1'b0);

        // Mid-period divisor change on ch0: old period finishes, then 5.
        apply_reset();
        pll_lock = 1'b1;
        wait_run(60, 60, 1'b0);
        for (int k = 2; k <= 130; k++) begin
            cyc("div_change",
                {ce_at(60, k), (k == 60) || ((k > 60) && ((k - 60) % 5 == 0))},
                1'b0, 1'b1, 1'b0);
            if (k == 21) begin
                div_value = 8'd5;
                div_load  = 2'b01;
            end else if (k == 22) begin
                div_load  = 2'b00;
            end
        end

        // Lock loss, sticky flag, clear, relock with preserved divisors.
        apply_reset();
        div_value = 8'd4;
        div_load  = 2'b01;
        cyc("preload_ch0", 2'b00, 1'b1, 1'b0, 1'b0);
        div_value = 8'd6;
        div_load  = 2'b10;
        cyc("preload_ch1", 2'b00, 1'b1, 1'b0, 1'b0);
        div_load  = 2'b00;
        pll_lock  = 1'b1;
        wait_run(4, 6, 1'b0);
        run_check("loss_pre", 4, 6, 2, 10, 1'b0);
        pll_lock = 1'b0;
        run_check("loss_sync", 4, 6, 11, 12, 1'b0);
        cyc("lock_lost", 2'b00, 1'b1, 1'b0, 1'b1);
        cyc("lost_sticky", 2'b00, 1'b1, 1'b0, 1'b1);
        cyc("lost_sticky", 2'b00, 1'b1, 1'b0, 1'b1);
        clear_lost = 1'b1;
        cyc("lost_clear", 2'b00, 1'b1, 1'b0, 1'b0);
        clear_lost = 1'b0;
        pll_lock   = 1'b1;
        wait_run(4, 6, 1'b0);
        run_check("relock", 4, 6, 2, 13, 1'b0);
        clear_lost = 1'b1;
        pll_lock   = 1'b0;
        run_check("loss2_sync", 4, 6, 14, 15, 1'b0);
        cyc("set_beats_clear", 2'b00, 1'b1, 1'b0, 1'b1);
        cyc("clear_after_set", 2'b00, 1'b1, 1'b0, 1'b0);
        clear_lost = 1'b0;

        // Asynchronous reset mid-run, pending shadow load is discarded.
        apply_reset();
        pll_lock = 1'b1;
        wait_run(60, 60, 1'b0);
        run_check("async_pre", 60, 60, 2, 5, 1'b0);
        div_value = 8'd9;
        div_load  = 2'b01;
        run_check("async_pre", 60, 60, 6, 6, 1'b0);
        div_load  = 2'b00;
        #3 rst = 1'b1;
        #1;
        push("async_reset_now", 2'b00, 1'b1, 1'b0, 1'b0);
        pop_check();
        cyc("async_reset_hold", 2'b00, 1'b1, 1'b0, 1'b0);
        rst = 1'b0;
        wait_run(60, 60, 1'b0);
        run_check("post_reset_div", 60, 60, 2, 65, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/clk_enable_gen.md
Name: clk_enable_gen

Overview:
- Parametrised successor to the fixed PLL clock wrapper. Runs on the PLL fast output clock; qualifies PLL lock, sequences downstream reset, and generates NUM_CH independent single-cycle clock-enable strobes at runtime-programmable divide ratios.
- Downstream logic stays in one clock domain and uses the enables, replacing per-ratio PLL divider outputs.
- Detects and reports loss of lock.

Parameters:
- NUM_CH, 2, number of clock-enable channels (1..8).
- DIV_WIDTH, 8, width of each channel divisor.
- DEFAULT_DIV, 60, divisor loaded into every channel at reset (must fit DIV_WIDTH).
- LOCK_WAIT, 1024, cycles synchronised lock must stay high before release (>=1).
- SYNC_STAGES, 2, synchroniser depth for in_pll_lock (>=2).

Ports:
- in_clk  input  1  fast clock (PLL CLKOUT).
- in_reset  input  1  asynchronous active-high reset.
- in_pll_lock  input  1  raw PLL LOCK, asynchronous to in_clk.
- in_div_load  input  NUM_CH  per-channel divisor load strobe.
- in_div_value  input  DIV_WIDTH  divisor value for any channel whose load bit is set.
- in_clear_lost  input  1  clears out_lock_lost.
- out_ce  output  NUM_CH  per-channel one-cycle enable strobe.
- out_rst  output  1  synchronous active-high reset for downstream logic.
- out_ready  output  1  high in RUN state.
- out_lock_lost  output  1  sticky: lock dropped while in RUN.

Behaviour:
- Reset values (async, in_reset high): state WAIT_LOCK; out_ce=0; out_rst=1; out_ready=0; out_lock_lost=0; synchroniser flops=0; settle counter=0; all channel counters=0; all active and shadow divisors=DEFAULT_DIV.
- Lock synchroniser: in_pll_lock passes through SYNC_STAGES flops to give lock_s. Latency is SYNC_STAGES cycles.
- FSM states:
  - WAIT_LOCK: settle counter held 0. Goes to SETTLE when lock_s=1.
  - SETTLE: settle counter increments each cycle. Goes back to WAIT_LOCK if lock_s=0, with the counter cleared. When the counter reaches LOCK_WAIT-1 with lock_s=1, goes to RUN.
  - RUN: goes to WAIT_LOCK when lock_s=0. The same cycle sets out_lock_lost=1.
- out_rst=1 in WAIT_LOCK and SETTLE; 0 in RUN. out_ready is the registered inverse of out_rst (same cycle, both registered).
- From the first cycle lock_s=1 to the first RUN cycle is exactly LOCK_WAIT cycles.
- Channel divider i, outside RUN: counter held 0; out_ce[i]=0.
- Channel divider i, in RUN:
  - Counter counts 0..D-1 and wraps, where D is the active divisor.
  - out_ce[i]=1 exactly when counter==D-1, so the period is D cycles and the duty cycle is one cycle.
  - First strobe is in the D-th RUN cycle. All channels start phase-aligned on RUN entry.
- Divisor 0 or 1 both mean divide-by-1: out_ce[i] held 1 throughout RUN.
- Divisor load:
  - Any in_div_load[i]=1 writes in_div_value into shadow[i]. Multiple bits may be set at once; last write before apply wins.
  - Outside RUN: shadow is copied to active the next cycle.
  - In RUN: shadow is copied to active only at terminal count. The strobe in that cycle is still produced with the old divisor. The new period starts at counter 0 the following cycle, so output is glitch-free with no truncated or stretched period.
  - A load in the same cycle as terminal count is applied at that terminal count.
- Lock loss mid-run: all out_ce drop to 0 the same cycle state leaves RUN (registered). Counters are cleared. Active divisors are kept.
- out_lock_lost: set on the RUN to WAIT_LOCK transition; cleared by in_clear_lost. If set and clear occur in the same cycle, set wins.
- in_reset asserted at any time returns every register to its reset value asynchronously. Shadow and active divisors return to DEFAULT_DIV.

Test Plan:
- Bench parameters for all scenarios: LOCK_WAIT=16, NUM_CH=2, SYNC_STAGES=2.
- Lock bring-up: release reset, raise in_pll_lock at cycle 10 → out_rst falls and out_ready rises at cycle 10+2+16. out_ce[0], out_ce[1] first pulse 60 cycles later, then every 60 cycles, aligned.
- Lock glitch in SETTLE: lock high for 8 cycles, low for 1, high again → settle restarts; RUN entered 16 cycles after the second rise (plus sync); out_lock_lost stays 0.
- Divisor change: in RUN, load 5 into ch0 mid-period (counter=20) → next ch0 strobe still at counter 59; subsequent strobes every 5 cycles; ch1 unaffected at 60.
- Divide-by-1 and 0: load 1 into ch0 and 0 into ch1 before lock → in RUN both out_ce held constantly 1.
- Lock loss: drop in_pll_lock in RUN → after 2 sync cycles, out_ce=0, out_rst=1, out_ready=0, out_lock_lost=1. Pulse in_clear_lost → out_lock_lost=0. Re-lock restarts with preserved divisors.
- Async reset mid-run: assert in_reset between clock edges → all outputs at reset values immediately; after release, ch0 divisor is back to 60.
